// File: rtl/pwm_arb_pkg.sv
// pwm_arb_pkg: shared types, defaults and helpers for the PWM write arbiter.
// Build option PWM_ARB_TIMEOUT_EN is consumed by pwm_wr_arbiter.
package pwm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } arb_state_e;

    localparam int unsigned NUM_REQ_DEF     = 4;
    localparam int unsigned FIFO_W_DEF      = 8;
    localparam int unsigned CFG_W_DEF       = 32;
    localparam int unsigned BURST_MAX_DEF   = 16;
    localparam int unsigned TIMEOUT_CYC_DEF = 64;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (a + b) mod n for a, b < n
    function automatic int unsigned wrap_add(
        input int unsigned a,
        input int unsigned b,
        input int unsigned n
    );
        int unsigned s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/pwm_rr_pick.sv
// pwm_rr_pick: combinational round-robin picker.
// Returns the first set request at or above ptr, wrapping past N-1.
module pwm_rr_pick
    import pwm_arb_pkg::*;
#(
    parameter int unsigned N  = NUM_REQ_DEF,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any
);

    // Scan from farthest to nearest so the nearest set bit wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_add(int'(ptr), k, N)]) begin
                winner = IW'(wrap_add(int'(ptr), k, N));
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_wr_arbiter.sv
// pwm_wr_arbiter: round-robin owner of one PWM write FIFO and config bus.
// Define PWM_ARB_TIMEOUT_EN to revoke a grant from an idle owner.
module pwm_wr_arbiter
    import pwm_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ           = NUM_REQ_DEF,
    parameter int unsigned PWM_FIFO_WIDTH    = FIFO_W_DEF,
    parameter int unsigned CONFIG_DATA_WIDTH = CFG_W_DEF,
    parameter int unsigned BURST_MAX         = BURST_MAX_DEF,
    parameter int unsigned TIMEOUT_CYC       = TIMEOUT_CYC_DEF,
    localparam int unsigned IW               = idx_w(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_last,
    input  logic [NUM_REQ*PWM_FIFO_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*CONFIG_DATA_WIDTH-1:0] req_cfg,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic                              fifo_afull,
    output logic                              wr_fifo_enable,
    output logic [PWM_FIFO_WIDTH-1:0]         wr_fifo_data,
    output logic [CONFIG_DATA_WIDTH-1:0]      pwm_config_data,
    output logic                              cfg_update,
    output logic [IW-1:0]                     grant_id,
    output logic                              busy,
    output logic                              timeout
);

    localparam int unsigned BW = idx_w(BURST_MAX);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);
    localparam logic [IW-1:0] ID_LAST = IW'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 ||
        BURST_MAX < 1 || (BURST_MAX & (BURST_MAX - 1)) != 0)
    begin : g_bad_cfg
        $error("pwm_wr_arbiter: unsupported parameter set");
    end

    arb_state_e state_q, state_d;

    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] pick_id, next_ptr;
    logic          pick_any;
    logic [BW-1:0] beat_q, beat_d;

    logic owner_valid, owner_last;
    logic hs, burst_done, to_fire;

    logic [PWM_FIFO_WIDTH-1:0]    owner_data, wr_data_q;
    logic [CONFIG_DATA_WIDTH-1:0] owner_cfg, cfg_q;
    logic                         wr_en_q, cfg_upd_q, timeout_q;

    assign owner_valid = req_valid[grant_q];
    assign owner_last  = req_last[grant_q];
    assign owner_data  =
        req_data[grant_q*PWM_FIFO_WIDTH +: PWM_FIFO_WIDTH];
    assign owner_cfg   =
        req_cfg[grant_q*CONFIG_DATA_WIDTH +: CONFIG_DATA_WIDTH];
    assign next_ptr    = (grant_q == ID_LAST) ? '0 : grant_q + 1'b1;

    pwm_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .winner (pick_id),
        .any    (pick_any)
    );

`ifdef PWM_ARB_TIMEOUT_EN
    localparam int unsigned TW = idx_w(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Only cycles where the owner shows no valid count; afull stalls do not.
    always_comb begin
        to_cnt_d = '0;
        to_fire  = 1'b0;
        if (state_q == XFER && !owner_valid) begin
            if (to_cnt_q == TO_LAST) begin
                to_fire = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_d     = beat_q;
        req_ready  = '0;
        hs         = 1'b0;
        burst_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_id;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = XFER;
            end
            XFER: begin
                req_ready[grant_q] = !fifo_afull;
                hs = owner_valid && !fifo_afull;
                if (hs) begin
                    if (owner_last || beat_q == BEAT_LAST) begin
                        burst_done = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                if (burst_done || to_fire) begin
                    state_d  = IDLE;
                    beat_d   = '0;
                    rr_ptr_d = next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            beat_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            cfg_q     <= '0;
            cfg_upd_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            beat_q    <= beat_d;
            wr_en_q   <= hs;
            cfg_upd_q <= (state_q == GRANT);
            timeout_q <= to_fire;
            if (hs) begin
                wr_data_q <= owner_data;
            end
            // New config lands together with its update pulse.
            if (state_q == GRANT) begin
                cfg_q <= owner_cfg;
            end
        end
    end

    assign wr_fifo_enable  = wr_en_q;
    assign wr_fifo_data    = wr_data_q;
    assign pwm_config_data = cfg_q;
    assign cfg_update      = cfg_upd_q;
    assign grant_id        = grant_q;
    assign busy            = (state_q != IDLE);
    assign timeout         = timeout_q;

endmodule

// File: tb/tb_pwm_wr_arbiter.sv
// tb_pwm_wr_arbiter: directed and random stimulus for pwm_wr_arbiter,
// checked against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_pwm_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 32;
    localparam int BM = 16;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*W-1:0]  req_data;
    logic [N*CW-1:0] req_cfg;
    logic [N-1:0]    req_ready;
    logic            fifo_afull;
    logic            wr_fifo_enable;
    logic [W-1:0]    wr_fifo_data;
    logic [CW-1:0]   pwm_config_data;
    logic            cfg_update;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout;

    always #5 clk = ~clk;

    pwm_wr_arbiter #(
        .NUM_REQ           (N),
        .PWM_FIFO_WIDTH    (W),
        .CONFIG_DATA_WIDTH (CW),
        .BURST_MAX         (BM),
        .TIMEOUT_CYC       (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_last        (req_last),
        .req_data        (req_data),
        .req_cfg         (req_cfg),
        .req_ready       (req_ready),
        .fifo_afull      (fifo_afull),
        .wr_fifo_enable  (wr_fifo_enable),
        .wr_fifo_data    (wr_fifo_data),
        .pwm_config_data (pwm_config_data),
        .cfg_update      (cfg_update),
        .grant_id        (grant_id),
        .busy            (busy),
        .timeout         (timeout)
    );

    // requester sources: pending bytes and their last flags
    logic [7:0] src_d [N][$];
    bit         src_l [N][$];
    logic [31:0] cfg_of [N];
    bit gate_on [N];
    int gate_pct, afull_pct;
    bit afull_force;

    // model: owner (-1 none), pointer, beats in burst, idle run
    int m_owner, m_ptr, m_beats, m_idle;
    bit m_gcyc;
    bit e_wr, e_cfg, e_to;
    logic [7:0]  e_wd;
    logic [31:0] m_cfg;

    int n_vec, n_err;
    int grant_log[$];
    int burst_len[$];
    int cur_len, n_writes, n_to;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += src_d[i].size();
        return s;
    endfunction

    task automatic push(input int r, input logic [7:0] d, input bit l);
        src_d[r].push_back(d);
        src_l[r].push_back(l);
    endtask

    task automatic push_rand(input int r, input int len);
        for (int k = 0; k < len; k++) push(r, 8'($urandom), k == len - 1);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        burst_len.delete();
        cur_len = 0;
        n_to = 0;
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_beats = 0; m_idle = 0; m_gcyc = 0;
        e_wr = 0; e_cfg = 0; e_to = 0; e_wd = '0; m_cfg = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_d[i].size() > 0) begin
                req_valid[i] = gate_on[i] &&
                               (int'($urandom_range(99)) < gate_pct);
                req_data[i*W +: W] = src_d[i][0];
                req_last[i] = src_l[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*W +: W] = '0;
                req_last[i] = 1'b0;
            end
        end
        fifo_afull = afull_force || (int'($urandom_range(99)) < afull_pct);
    endtask

    task automatic check_outputs();
        logic [N-1:0] er;
        er = '0;
        if (m_owner >= 0 && !m_gcyc) er[m_owner] = !fifo_afull;
        chk("req_ready", req_ready, er);
        chk("wr_en", wr_fifo_enable, e_wr);
        if (e_wr) chk("wr_data", wr_fifo_data, e_wd);
        chk("cfg_update", cfg_update, e_cfg);
        chk("cfg_data", pwm_config_data, m_cfg);
        chk("busy", busy, m_owner >= 0);
        if (m_owner >= 0) chk("grant_id", grant_id, m_owner);
        chk("timeout", timeout, e_to);
        if (cfg_update) begin
            grant_log.push_back(int'(grant_id));
            burst_len.push_back(cur_len);
            cur_len = 0;
        end
        if (wr_fifo_enable) begin
            cur_len++;
            n_writes++;
        end
        if (timeout) n_to++;
    endtask

    // Arbitration rules applied to what was driven this cycle.
    task automatic advance_model();
        logic [N-1:0] v;
        bit done, found;
        v = req_valid;
        done = 0;
        e_wr = 0; e_cfg = 0; e_to = 0;
        if (m_owner < 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && v[(m_ptr + k) % N]) begin
                    found = 1;
                    m_owner = (m_ptr + k) % N;
                end
            end
            if (found) begin
                m_gcyc = 1; m_beats = 0; m_idle = 0;
            end
        end else if (m_gcyc) begin
            m_gcyc = 0;
            e_cfg = 1;
            m_cfg = cfg_of[m_owner];
        end else begin
            if (v[m_owner] && !fifo_afull) begin
                e_wr = 1;
                e_wd = src_d[m_owner][0];
                m_beats++;
                done = src_l[m_owner][0] || (m_beats == BM);
                void'(src_d[m_owner].pop_front());
                void'(src_l[m_owner].pop_front());
            end
            if (v[m_owner]) begin
                m_idle = 0;
            end else begin
`ifdef PWM_ARB_TIMEOUT_EN
                m_idle++;
                if (m_idle == TO) begin
                    done = 1;
                    e_to = 1;
                end
`endif
            end
            if (done) begin
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic step();
        drive();
        #1;
        check_outputs();
        advance_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ready", req_ready, '0);
        chk("rst_wr_en", wr_fifo_enable, 0);
        chk("rst_wr_data", wr_fifo_data, 0);
        chk("rst_cfg", pwm_config_data, 0);
        chk("rst_cfg_upd", cfg_update, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_drain(input int max);
        int c = 0;
        while ((pending() != 0 || m_owner >= 0 || e_wr) && c < max) begin
            step();
            c++;
        end
        chk("drain", pending() + int'(m_owner >= 0), 0);
        step();
        step();
    endtask

    int w0, c;
    bit snap;

    initial begin
        n_vec = 0; n_err = 0; n_writes = 0;
        rst_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        fifo_afull = 1'b0; afull_force = 0;
        gate_pct = 100; afull_pct = 0;
        for (int i = 0; i < N; i++) begin
            cfg_of[i] = $urandom;
            req_cfg[i*CW +: CW] = cfg_of[i];
            gate_on[i] = 1;
        end
        clear_logs();
        model_reset();
        @(negedge clk);
        do_reset();

        // all requesters busy: strict rotation from requester 0
        clear_logs();
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < N; i++) push(i, 8'($urandom), 1);
        run_drain(100);
        chk("rot_count", grant_log.size(), 2 * N);
        for (int k = 0; k < grant_log.size(); k++)
            chk("rot_order", grant_log[k], k % N);

        // single 3-beat burst from requester 0
        clear_logs();
        w0 = n_writes;
        push(0, 8'h10, 0);
        push(0, 8'h20, 0);
        push(0, 8'h30, 1);
        run_drain(40);
        chk("p3_writes", n_writes - w0, 3);
        chk("p3_grants", grant_log.size(), 1);
        chk("p3_owner", grant_log[0], 0);

        // 20 beats without last: forced release at BURST_MAX
        clear_logs();
        w0 = n_writes;
        push_rand(2, 20);
        run_drain(80);
        burst_len.push_back(cur_len);
        chk("bm_writes", n_writes - w0, 20);
        chk("bm_bursts", burst_len.size(), 3);
        chk("bm_first", burst_len[1], BM);
        chk("bm_second", burst_len[2], 20 - BM);
        chk("bm_regrant", grant_log[1], 2);

        // fifo_afull held for 5 cycles mid-burst
        clear_logs();
        w0 = n_writes;
        push_rand(1, 8);
        repeat (4) step();
        snap = e_wr;
        c = n_writes;
        afull_force = 1;
        repeat (5) step();
        afull_force = 0;
        chk("afull_nowr", n_writes - c, int'(snap));
        run_drain(40);
        chk("afull_total", n_writes - w0, 8);

        // random traffic with random valid gaps and back-pressure
        gate_pct = 70;
        afull_pct = 20;
        repeat (300) begin
            for (int i = 0; i < N; i++)
                if (src_d[i].size() == 0 && $urandom_range(3) == 0)
                    push_rand(i, int'($urandom_range(20, 1)));
            step();
        end
        gate_pct = 100;
        afull_pct = 0;
        run_drain(600);

        // reset during beat 2 of a burst
        push_rand(3, 6);
        c = 0;
        while (!(m_owner == 3 && m_beats == 2) && c < 30) begin
            step();
            c++;
        end
        chk("rst_reach", m_beats, 2);
        do_reset();
        for (int i = 0; i < N; i++) begin
            src_d[i].delete();
            src_l[i].delete();
        end
        clear_logs();
        push(3, 8'h5a, 1);
        push(0, 8'ha5, 1);
        run_drain(40);
        chk("rst_grants", grant_log.size(), 2);
        chk("rst_first", grant_log[0], 0);
        chk("rst_second", grant_log[1], 3);

        // owner drops valid mid-burst for 70 cycles
        clear_logs();
        push_rand(1, 4);
        push(2, 8'h77, 1);
        c = 0;
        while (!(m_owner == 1 && !m_gcyc && m_beats == 1) && c < 20) begin
            step();
            c++;
        end
        chk("hold_reach", m_beats, 1);
        gate_on[1] = 0;
        repeat (70) step();
`ifdef PWM_ARB_TIMEOUT_EN
        chk("to_pulses", n_to, 1);
`else
        chk("to_pulses", n_to, 0);
        chk("hold_busy", busy, 1);
`endif
        gate_on[1] = 1;
        run_drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
